// File: rtl/panel_power_seq_if.sv
// Handshake bundle between the panel sequencer and its controller:
// power-up/down requests in, panel pin / lane / status levels out.
interface panel_power_seq_if;
  logic start;
  logic stop;
  logic panel_rst_n;
  logic lanes_en;
  logic ready;
  logic busy;

  modport master (
    output start,
    output stop,
    input  panel_rst_n,
    input  lanes_en,
    input  ready,
    input  busy
  );

  modport slave (
    input  start,
    input  stop,
    output panel_rst_n,
    output lanes_en,
    output ready,
    output busy
  );
endinterface

// File: rtl/panel_power_seq.sv
// DSI panel power/reset sequencer. Walks the panel through a timed
// reset-assert / init window into READY on start, and back to a held-reset,
// lanes-off OFF state on stop. Outputs are flops decoded from the state
// register, so they follow the state by one cycle.
module panel_power_seq #(
  parameter int unsigned T_RST  = 16,
  parameter int unsigned T_INIT = 1024,
  parameter int unsigned T_OFF  = 8
) (
  input  logic               clk,
  input  logic               rst,
  panel_power_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_OFF,
    S_ASSERT,
    S_INIT,
    S_READY,
    S_SHUTDOWN
  } state_t;

  localparam logic [15:0] LD_RST  = 16'(T_RST  - 1);
  localparam logic [15:0] LD_INIT = 16'(T_INIT - 1);
  localparam logic [15:0] LD_OFF  = 16'(T_OFF  - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        rst_n_q, lanes_q, ready_q, busy_q;
  logic        rst_n_d, lanes_d, ready_d, busy_d;

  // State, counter and output registers; outputs take the decode of the
  // current state, giving them a one-cycle lag behind the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_OFF;
      cnt     <= '0;
      rst_n_q <= 1'b0;
      lanes_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rst_n_q <= rst_n_d;
      lanes_q <= lanes_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state / counter logic; stop outranks start and expiry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_OFF: begin
        if (bus.start && !bus.stop) begin
          state_nx = S_ASSERT;
          cnt_nx   = LD_RST;
        end
      end
      S_ASSERT: begin
        if (bus.stop) begin
          state_nx = S_SHUTDOWN;
          cnt_nx   = LD_OFF;
        end else if (cnt == '0) begin
          state_nx = S_INIT;
          cnt_nx   = LD_INIT;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      S_INIT: begin
        if (bus.stop) begin
          state_nx = S_SHUTDOWN;
          cnt_nx   = LD_OFF;
        end else if (cnt == '0) begin
          state_nx = S_READY;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      S_READY: begin
        if (bus.stop) begin
          state_nx = S_SHUTDOWN;
          cnt_nx   = LD_OFF;
        end
      end
      S_SHUTDOWN: begin
        if (cnt == '0) begin
          state_nx = S_OFF;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: begin
        state_nx = S_OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    rst_n_d = 1'b0;
    lanes_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    unique case (state)
      S_ASSERT:   busy_d = 1'b1;
      S_INIT: begin
        rst_n_d = 1'b1;
        lanes_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_READY: begin
        rst_n_d = 1'b1;
        lanes_d = 1'b1;
        ready_d = 1'b1;
      end
      S_SHUTDOWN: busy_d = 1'b1;
      default:    ;
    endcase
  end

  assign bus.panel_rst_n = rst_n_q;
  assign bus.lanes_en    = lanes_q;
  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/panel_power_seq.md
# panel_power_seq

Panel power/reset sequencer, downstream consumer of the power-on reset generator. Once the internal reset is released, it waits for a start request, then drives the DSI panel's active-low reset pin through a timed assert/release sequence. It enables the lane drivers into LP-11 and signals `ready` to the command/video path. On a stop request it performs the inverse sequence, so the panel is always left held in reset with lanes off.

## Interface
Parameters:
- `T_RST`, default 16: cycles `panel_rst_n` is held low in ASSERT; range 1..65535.
- `T_INIT`, default 1024: cycles from panel-reset release to `ready`; range 1..65535.
- `T_OFF`, default 8: cycles spent in SHUTDOWN before returning to OFF; range 1..65535.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high; driven by the power-on reset generator.
- `start` in 1: power-up request, sampled each edge; acted on only in OFF.
- `stop` in 1: power-down request, sampled each edge; acted on in ASSERT, INIT and READY.
- `panel_rst_n` out 1: panel reset pin, active low.
- `lanes_en` out 1: DSI lane driver enable; 1 means lanes at LP-11.
- `ready` out 1: panel initialised; command/video path may transmit.
- `busy` out 1: high in ASSERT, INIT and SHUTDOWN.

## Operation
- All outputs are registered and decoded from the registered state. No combinational path from input to output.
- Reset values: state=OFF, counter=0, `panel_rst_n`=0, `lanes_en`=0, `ready`=0, `busy`=0.
- Single 16-bit down-counter. It is loaded with (duration − 1) on entry to a timed state and decrements each cycle. The state exits on the cycle the counter reads 0. Each timed state therefore lasts exactly its parameter in cycles.
- States and the outputs they drive (`panel_rst_n`/`lanes_en`/`ready`/`busy`):
  - OFF: 0/0/0/0. `start`=1 → ASSERT.
  - ASSERT: 0/0/0/1. Count expires → INIT.
  - INIT: 1/1/0/1. Count expires → READY.
  - READY: 1/1/1/0. `stop`=1 → SHUTDOWN.
  - SHUTDOWN: 0/0/0/1. Count expires → OFF.
- `stop` in ASSERT or INIT aborts immediately to SHUTDOWN, with full T_OFF.
- `start` and `stop` sampled high together: `stop` wins. In OFF both are ignored, so the block stays in OFF.
- `start` outside OFF is ignored; requests are not queued. A `start` during SHUTDOWN has no effect.
- `stop` in OFF or SHUTDOWN is ignored; the counter is not restarted.
- `start`/`stop` held high are level-tolerant: a held `start` re-triggers only after returning to OFF.
- `rst` asserted in any state forces the reset values on the next edge. The panel pin therefore drops low immediately, which is an accepted abrupt power-down.

## Timing
- `start` sampled at edge k → `busy`=1 from edge k+1.
- `panel_rst_n` and `lanes_en` rise at edge k+1+T_RST.
- `ready` rises and `busy` falls at edge k+1+T_RST+T_INIT.
- `stop` sampled at edge m in READY → `ready`, `lanes_en` and `panel_rst_n` fall and `busy` rises at edge m+1.
- `busy`=0 again at edge m+1+T_OFF. The earliest accepted new `start` is sampled at that same edge.
- `panel_rst_n` and `lanes_en` change on the same edge in every transition.

## Test plan
Bench parameters: T_RST=4, T_INIT=6, T_OFF=3.
- Reset: hold `rst` 3 cycles with `start`=1 → all outputs 0 throughout. After release with `start` low, the block stays in OFF.
- Power-up: pulse `start` at edge 10 → `busy` 1 at 11; `panel_rst_n` and `lanes_en` 1 at 15; `ready` 1 and `busy` 0 at 21.
- Power-down: `stop` at edge 30 in READY → all of `ready`/`lanes_en`/`panel_rst_n` 0 at 31; `busy` 1 from 31 to 33, 0 at 34. A `start` at 32 is ignored; a `start` at 34 → `busy` at 35.
- Abort: `start` at 10, `stop` at 17 (INIT) → `panel_rst_n` 0 at 18, `busy` 0 at 21, `ready` never 1.
- Conflict: `start` and `stop` both high at edge 10 in OFF → no transition. Both high at edge 25 in READY → SHUTDOWN at 26.
- Mid-operation reset: `rst` high at edge 13 during ASSERT → all outputs 0 at 14. After release, a fresh `start` reproduces the power-up timing exactly.
